// File: rtl/multdiv_sequencer.sv
// Multicycle MULT/MULTU/DIV/DIVU unit with private HI/LO, shift-add / restoring divide.
// Optional build macro MULTDIV_FAST_MULT_EN: single-cycle combinational product for multiplies.
module multdiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;

    state_t             state;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_raw, b_raw, opnd;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic               neg_res, neg_rem, dz;

    logic               is_div, is_signed, a_neg, b_neg;
    logic [WIDTH-1:0]   abs_a, abs_b, quo_fix, rem_fix;
    logic [WIDTH:0]     msum, trial;
    logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
`ifdef MULTDIV_FAST_MULT_EN
    logic [2*WIDTH-1:0] fast_prod;
`endif

    always_comb begin
        is_div    = op_q[1];
        is_signed = ~op_q[0];
        a_neg     = is_signed & a_raw[WIDTH-1];
        b_neg     = is_signed & b_raw[WIDTH-1];
        abs_a     = a_neg ? -a_raw : a_raw;
        abs_b     = b_neg ? -b_raw : b_raw;
        // acc = {partial product, remaining multiplier bits}; carry lands in the top bit on shift
        msum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
        mul_next  = acc[0] ? {msum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
        // acc = {remainder, dividend/quotient}; trial MSB set means restore
        trial     = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
        div_next  = trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                 : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        prod_fix  = neg_res ? -acc : acc;
        quo_fix   = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix   = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
`ifdef MULTDIV_FAST_MULT_EN
        fast_prod = {{WIDTH{1'b0}}, abs_a} * {{WIDTH{1'b0}}, abs_b};
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            op_q        <= '0;
            a_raw       <= '0;
            b_raw       <= '0;
            opnd        <= '0;
            acc         <= '0;
            cnt         <= '0;
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
            dz          <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        a_raw <= src_a;
                        b_raw <= src_b;
                        busy  <= 1'b1;
                        state <= PREP;
                    end else begin
                        if (mthi) hi <= wdata;
                        if (mtlo) lo <= wdata;
                    end
                end
                PREP: begin
                    neg_res <= a_neg ^ b_neg;
                    neg_rem <= a_neg;
                    cnt     <= '0;
                    dz      <= 1'b0;
                    acc     <= '0;
                    if (is_div) begin
                        opnd  <= abs_b;
                        acc   <= {{WIDTH{1'b0}}, abs_a};
                        state <= RUN;
                        // zero divisor burns a single idle RUN slot so done lands at edge 3
                        if (b_raw == '0) begin
                            dz  <= 1'b1;
                            cnt <= LAST;
                        end
                    end else begin
`ifdef MULTDIV_FAST_MULT_EN
                        acc   <= fast_prod;
                        state <= FIX;
`else
                        opnd  <= abs_a;
                        acc   <= {{WIDTH{1'b0}}, abs_b};
                        state <= RUN;
`endif
                    end
                end
                RUN: begin
                    if (!dz) acc <= is_div ? div_next : mul_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) state <= FIX;
                end
                FIX: begin
                    if (dz) begin
                        hi          <= a_raw;
                        lo          <= '1;
                        div_by_zero <= 1'b1;
                    end else if (is_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multdiv_sequencer.sv
// Randomized scoreboard bench for multdiv_sequencer: stimulus pushes model results, monitor checks on done.
module tb_multdiv_sequencer;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, mthi = 1'b0, mtlo = 1'b0;
    logic [1:0]  op = '0;
    logic [31:0] src_a = '0, src_b = '0, wdata = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    multdiv_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef MULTDIV_FAST_MULT_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 34;
`endif

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          t0;
        int          lat;
    } exp_t;

    exp_t        scb[$];
    logic [31:0] cur_hi = '0, cur_lo = '0;
    int          vectors = 0, miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                   input int t0);
        exp_t        e;
        longint      sa, sbv, q, r;
        logic [63:0] p;
        sa = $signed(a);
        sbv = $signed(b);
        e.t0 = t0;
        e.dz = 1'b0;
        e.lat = 34;
        case (o)
            2'd0: begin p = sa * sbv; e.hi = p[63:32]; e.lo = p[31:0]; e.lat = MUL_LAT; end
            2'd1: begin p = {32'd0, a} * {32'd0, b}; e.hi = p[63:32]; e.lo = p[31:0]; e.lat = MUL_LAT; end
            default: begin
                if (b == 0) begin
                    e.hi = a; e.lo = 32'hFFFF_FFFF; e.dz = 1'b1; e.lat = 3;
                end else if (o == 2'd2) begin
                    q = sa / sbv; r = sa % sbv;
                    p = q; e.lo = p[31:0];
                    p = r; e.hi = p[31:0];
                end else begin
                    e.lo = a / b; e.hi = a % b;
                end
            end
        endcase
        return e;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            if (done) begin
                if (scb.size() == 0) check("spurious_done", done, 0);
                else begin
                    e = scb.pop_front();
                    check("hi", hi, e.hi);
                    check("lo", lo, e.lo);
                    check("div_by_zero", div_by_zero, e.dz);
                    check("latency", cyc - e.t0, e.lat);
                    cur_hi = e.hi;
                    cur_lo = e.lo;
                end
            end
            if (div_by_zero && !done) check("dz_without_done", div_by_zero, 0);
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) check("idle_timeout", busy, 0);
    endtask

    // Drives start in the first idle cycle (possibly the done cycle) and returns its sampling edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int t0);
        wait_idle();
        op = o; src_a = a; src_b = b; start = 1'b1;
        t0 = cyc + 1;
        scb.push_back(model(o, a, b, t0));
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int t0, sel;
        logic [1:0]  o;
        logic [31:0] a, b;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dz", div_by_zero, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(2'd0, 32'hFFFF_FFFE, 32'd3, t0);
        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, t0);
        issue(2'd2, 32'hFFFF_FFF9, 32'd2, t0);
        issue(2'd3, 32'h0000_1234, 32'd0, t0);
        issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, t0);
        issue(2'd2, 32'hFFFF_FFF0, 32'd0, t0);
        issue(2'd0, 32'h8000_0000, 32'h8000_0000, t0);

        // HI/LO must hold during the iterations
        issue(2'd3, 32'd100, 32'd7, t0);
        repeat (10) @(posedge clk);
        #1;
        check("hi_hold_run", hi, cur_hi);
        check("lo_hold_run", lo, cur_lo);

        // start held high and mthi pulsed while busy: neither restarts nor writes HI
        wait_idle();
        op = 2'd3; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
        scb.push_back(model(2'd3, 32'd1000, 32'd3, cyc + 1));
        repeat (5) @(posedge clk);
        #1;
        mthi = 1'b1; wdata = 32'hAA;
        @(posedge clk); #1;
        mthi = 1'b0;
        check("busy_held", busy, 1);
        check("hi_no_mthi_busy", hi, cur_hi);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b0;

        // start and mthi together in IDLE: move is dropped
        wait_idle();
        repeat (2) @(posedge clk);
        #1;
        op = 2'd1; src_a = 32'd9; src_b = 32'd9; start = 1'b1; mthi = 1'b1; wdata = 32'hDEAD_BEEF;
        scb.push_back(model(2'd1, 32'd9, 32'd9, cyc + 1));
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0;
        check("start_wins_hi", hi, cur_hi);

        // moves in IDLE
        wait_idle();
        repeat (2) @(posedge clk);
        #1;
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h55;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b0;
        check("mthi_mtlo_hi", hi, 32'h55);
        check("mthi_mtlo_lo", lo, 32'h55);
        check("move_no_done", done, 0);
        cur_hi = 32'h55; cur_lo = 32'h55;
        mtlo = 1'b1; wdata = 32'h77;
        @(posedge clk); #1;
        mtlo = 1'b0;
        check("mtlo_lo", lo, 32'h77);
        check("mtlo_hi_kept", hi, 32'h55);
        cur_lo = 32'h77;

        // asynchronous reset at edge 10 of a divide
        issue(2'd2, 32'd12345, 32'd17, t0);
        while (cyc < t0 + 10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        scb.delete();
        #1;
        check("arst_busy", busy, 0);
        check("arst_hi", hi, 0);
        check("arst_lo", lo, 0);
        cur_hi = '0; cur_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        issue(2'd2, 32'hFFFF_FF00, 32'd7, t0);

        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0: b = 32'd0;
                1: b = 32'd1;
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: b = 32'($urandom_range(1, 15));
                4: b = -32'($urandom_range(1, 15));
                default: ;
            endcase
            issue(o, a, b, t0);
        end

        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drain", scb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
